cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Miss-handling controller shared by the I-cache and D-cache. When the cache tag check reports a miss, it fetches the whole 16-byte block (eight 16-bit words) from the 4-cycle pipelined main memory, streams each returned word into the cache data array, then writes the tag. It holds the pipeline stall (`stall_I` / `stall_D` in the top level) through `fsm_busy` for the whole fill. One instance sits between each cache and the memory-side read port (`MemRead_*`, `mem_read_addr_*`, `MemDataValid_*`, `mem_read_data_*`).

## Interface
Parameters:
- ADDR_W, 16, byte-address width
- WORDS, 8, 16-bit words per block; offset bits = log2(WORDS)+1
- MEM_LAT, 4, memory read latency in cycles; documentation only, the FSM counts valids

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- miss_detected  in  1  tag miss this cycle, from the cache
- miss_address  in  16  byte address of the missing access
- mem_data_valid  in  1  memory returns a word this cycle
- mem_data  in  16  returned word
- fsm_busy  out  1  fill in progress; drives the stall
- mem_read_en  out  1  issue a read to memory this cycle
- mem_address  out  16  word-aligned read address
- write_data_array  out  1  write `write_data` at `write_addr`
- write_addr  out  16  byte address of the word being written
- write_data  out  16  equals `mem_data`
- write_tag_array  out  1  write tag and valid for the block base address

## Operation
- States: IDLE, FILL.
- IDLE:
  - On `miss_detected`, capture `base = {miss_address[15:4], 4'b0}`, clear `issue_cnt` and `recv_cnt`, go to FILL.
  - `fsm_busy` = `miss_detected` (combinational), so the stall starts in the miss cycle.
- FILL:
  - `fsm_busy` = 1.
  - While `issue_cnt` < 8: `mem_read_en` = 1, `mem_address` = base + 2·`issue_cnt`, then `issue_cnt`++.
  - On each `mem_data_valid`: `write_data_array` = 1, `write_addr` = base + 2·`recv_cnt`, then `recv_cnt`++.
  - When `recv_cnt` == 7 and `mem_data_valid` = 1: also assert `write_tag_array` (address = base) in the same cycle, then go to IDLE.
- Counters are 4 bits so that the value 8 marks "all issued". Address arithmetic is modulo 2^16. The block never crosses a 16-byte boundary because offsets stay at or below 14.
- Ignored inputs:
  - `miss_detected` during FILL, so back-to-back misses never restart a fill.
  - `mem_data_valid` in IDLE.
- Words are written strictly in return order, which equals issue order.
- Reset (asynchronous, any time, including mid-fill):
  - Forces IDLE; clears counters and `base`.
  - All outputs go to 0.
  - Memory shares `rst`, so no stale returns follow.

## Timing
- The miss is seen in cycle 0 (IDLE). The first issue happens in cycle 1, and issues continue every cycle through cycle 8.
- With MEM_LAT = 4, valids arrive in cycles 5–12. `write_tag_array` pulses in cycle 12. IDLE and `fsm_busy` = 0 from cycle 13.
- Total stall is 13 cycles.
- A new miss is accepted in cycle 13 at the earliest.
- If valids arrive late or with gaps, the FSM waits. `fsm_busy` stays high until the 8th valid.
- Outputs decode from registered state, counters and inputs, and are glitch-free at the edge. `write_*` follow `mem_data_valid` with zero latency.

## Structure
- Package `cache_pkg`:
  - `fill_state_t` enum {IDLE, FILL}
  - constants BLOCK_BYTES = 16, WORDS = 8, OFFSET_W = 4
- Sub-module `fill_counter`: 4-bit counter with synchronous clear, enable and asynchronous reset. Instantiated twice, for `issue_cnt` and `recv_cnt`.
- The same module serves both caches. The top level gates `mem_read_en` of the I-side and D-side instances through its memory arbitration.

## Test plan
- Reset/idle:
  - Hold `rst` = 1 → all outputs 0.
  - Release `rst`, no miss for 20 cycles → `fsm_busy`, `mem_read_en` and all `write_*` remain 0.
- Basic fill:
  - Miss at `miss_address` 0x1236 → `mem_address` 0x1230, 0x1232 … 0x123E in cycles 1–8.
  - The memory model returns 0xA000+i → writes 0x1230←0xA000 … 0x123E←0xA007 in cycles 5–12.
  - `write_tag_array` pulses only in cycle 12; `fsm_busy` = 0 in cycle 13.
- Wrap address: miss at 0xFFF4 → addresses 0xFFF0–0xFFFE, with no carry into the tag.
- Irregular memory:
  - Valids delayed, with 3-cycle gaps after words 2 and 5 → exactly 8 writes in order.
  - `fsm_busy` falls only one cycle after the 8th valid.
- Ignored inputs:
  - `miss_detected` pulsed with 0x4000 during a fill of 0x2000 → no restart, base stays 0x2000.
  - A stray `mem_data_valid` in IDLE → no write.
- Mid-fill reset: assert `rst` asynchronously after 3 writes → outputs 0 immediately, state IDLE. A fresh miss at 0x0050 then completes a normal 13-cycle fill.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and block-geometry constants for the cache miss/fill controller.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int BLOCK_BYTES = 16;
    localparam int WORDS       = 8;
    localparam int OFFSET_W    = 4;

endpackage

// File: rtl/fill_counter.sv
// Small word counter used for both the issue and receive sides of a block fill.
module fill_counter
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    output logic [OFFSET_W-1:0] cnt
);

    // Clear wins over enable so a new fill always starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + OFFSET_W'(1);
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-handling controller: fetches a whole block from pipelined memory,
// streams each returned word into the data array, then writes the tag.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              mem_data_valid,
    input  logic [15:0]       mem_data,
    output logic              fsm_busy,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] write_addr,
    output logic [15:0]       write_data,
    output logic              write_tag_array
);

    // The FSM counts valids rather than cycles, so latency only matters for sanity.
    if (MEM_LAT < 1 || WORDS != cache_pkg::WORDS) begin : g_param_err
        $error("cache_fill_fsm: unsupported MEM_LAT/WORDS");
    end

    fill_state_t             state, state_nxt;
    logic [ADDR_W-1:0]       base;
    logic [OFFSET_W-1:0]     issue_cnt, recv_cnt;
    logic                    cnt_clr, issue_en, recv_en;

    fill_counter u_issue_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (issue_en),
        .cnt (issue_cnt)
    );

    fill_counter u_recv_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (recv_en),
        .cnt (recv_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            base  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && miss_detected)
                base <= {miss_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        end
    end

    always_comb begin
        state_nxt        = state;
        cnt_clr          = 1'b0;
        issue_en         = 1'b0;
        recv_en          = 1'b0;
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        mem_address      = '0;
        write_data_array = 1'b0;
        write_addr       = '0;
        write_data       = '0;
        write_tag_array  = 1'b0;
        case (state)
            IDLE: begin
                // Stall starts in the miss cycle itself; reset forces it low.
                fsm_busy = miss_detected & ~rst;
                if (miss_detected) begin
                    cnt_clr   = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (issue_cnt < OFFSET_W'(WORDS)) begin
                    mem_read_en = 1'b1;
                    mem_address = base + (ADDR_W'(issue_cnt) << 1);
                    issue_en    = 1'b1;
                end
                // Offsets stay <= 14, so the add never carries into the tag.
                if (mem_data_valid) begin
                    write_data_array = 1'b1;
                    write_addr       = base + (ADDR_W'(recv_cnt) << 1);
                    write_data       = mem_data;
                    recv_en          = 1'b1;
                    if (recv_cnt == OFFSET_W'(WORDS - 1)) begin
                        write_tag_array = 1'b1;
                        state_nxt       = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: cycle-accurate fills against hand-derived schedules.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        mem_data_valid;
    logic [15:0] mem_data;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] mem_address;
    logic        write_data_array;
    logic [15:0] write_addr;
    logic [15:0] write_data;
    logic        write_tag_array;

    int n_chk  = 0;
    int n_pass = 0;

    cache_fill_fsm #(.ADDR_W(16), .WORDS(8), .MEM_LAT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .mem_data_valid   (mem_data_valid),
        .mem_data         (mem_data),
        .fsm_busy         (fsm_busy),
        .mem_read_en      (mem_read_en),
        .mem_address      (mem_address),
        .write_data_array (write_data_array),
        .write_addr       (write_addr),
        .write_data       (write_data),
        .write_tag_array  (write_tag_array)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(fsm_busy), 32'd0);
        chk({tag, "_rd"},   32'(mem_read_en), 32'd0);
        chk({tag, "_ra"},   32'(mem_address), 32'd0);
        chk({tag, "_wda"},  32'(write_data_array), 32'd0);
        chk({tag, "_wa"},   32'(write_addr), 32'd0);
        chk({tag, "_wd"},   32'(write_data), 32'd0);
        chk({tag, "_tag"},  32'(write_tag_array), 32'd0);
    endtask

    // One fill from the miss cycle (c=0). Valid schedule: cycles 5..12, or with
    // gaps a 2-cycle late start plus 3-cycle gaps after the 3rd and 6th word.
    // abort_c >= 0 asserts rst asynchronously mid-cycle at that cycle.
    task automatic do_fill(input logic [15:0] addr, input bit gaps, input bit inject,
                           input int abort_c);
        logic [15:0] b;
        logic [15:0] ea;
        int          vc[8];
        int          k;
        int          last;
        bit          v;
        bit          rd;
        b = {addr[15:4], 4'h0};
        for (int i = 0; i < 8; i++)
            vc[i] = gaps ? (7 + i + (i >= 3 ? 3 : 0) + (i >= 6 ? 3 : 0)) : (5 + i);
        last = vc[7];
        k    = 0;
        for (int c = 0; c <= last + 2; c++) begin
            @(posedge clk); #1;
            miss_detected  = (c == 0) || (inject && c == 3);
            miss_address   = (c == 0) ? addr : 16'h4000;
            v              = (k < 8) && (c == vc[k]);
            mem_data_valid = v;
            mem_data       = v ? 16'(16'hA000 + k) : 16'h5555;
            if (c == abort_c) begin
                #1 rst = 1'b1;
                #1;
                chk_all_zero($sformatf("abort_c%0d", c));
                mem_data_valid = 1'b0;
                miss_detected  = 1'b0;
                return;
            end
            @(negedge clk);
            rd = (c >= 1) && (c <= 8);
            chk($sformatf("busy_%h_c%0d", addr, c), 32'(fsm_busy), 32'(c <= last));
            chk($sformatf("rd_%h_c%0d", addr, c), 32'(mem_read_en), 32'(rd));
            ea = rd ? 16'(b + 2 * (c - 1)) : 16'h0;
            chk($sformatf("ra_%h_c%0d", addr, c), 32'(mem_address), 32'(ea));
            chk($sformatf("wda_%h_c%0d", addr, c), 32'(write_data_array), 32'(v));
            ea = v ? 16'(b + 2 * k) : 16'h0;
            chk($sformatf("wa_%h_c%0d", addr, c), 32'(write_addr), 32'(ea));
            chk($sformatf("wd_%h_c%0d", addr, c), 32'(write_data),
                v ? 32'(16'hA000 + k) : 32'd0);
            chk($sformatf("tag_%h_c%0d", addr, c), 32'(write_tag_array), 32'(v && k == 7));
            if (v) k++;
        end
        miss_detected  = 1'b0;
        mem_data_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        miss_detected  = 1'b1;
        miss_address   = 16'h1236;
        mem_data_valid = 1'b1;
        mem_data       = 16'hBEEF;
        #12;
        chk_all_zero("reset");

        @(posedge clk); #1;
        rst            = 1'b0;
        miss_detected  = 1'b0;
        mem_data_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle_busy_%0d", i), 32'(fsm_busy), 32'd0);
            chk($sformatf("idle_rd_%0d", i), 32'(mem_read_en), 32'd0);
            chk($sformatf("idle_wda_%0d", i), 32'(write_data_array), 32'd0);
            chk($sformatf("idle_tag_%0d", i), 32'(write_tag_array), 32'd0);
        end

        do_fill(16'h1236, 1'b0, 1'b0, -1);
        do_fill(16'hFFF4, 1'b0, 1'b0, -1);
        do_fill(16'h3456, 1'b1, 1'b0, -1);
        do_fill(16'h2000, 1'b0, 1'b1, -1);

        // Stray valid in IDLE must not write.
        @(posedge clk); #1;
        mem_data_valid = 1'b1;
        mem_data       = 16'h1234;
        @(negedge clk);
        chk_all_zero("stray_valid");
        mem_data_valid = 1'b0;

        // Asynchronous reset after three writes, mid-issue.
        do_fill(16'h0C48, 1'b0, 1'b0, 8);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("post_rst_idle");
        do_fill(16'h0050, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
